// File: rtl/incubator_sched.sv
// Incubator heater/cooler scheduler: four-state FSM with minimum-on and guard dwell times.
// Optional over-temperature alarm qualifier enabled by defining INCUBATOR_ALARM_EN.
module incubator_sched #(
  parameter int unsigned MIN_ON    = 16,
  parameter int unsigned GUARD_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] T,
  output logic       Heater,
  output logic       Cooler,
  output logic [1:0] STATE,
  output logic       ALARM
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StHeat  = 2'b01,
    StCool  = 2'b10,
    StGuard = 2'b11
  } state_e;

  localparam logic [7:0] MinOn    = MIN_ON[7:0];
  localparam logic [7:0] GuardCyc = GUARD_CYC[7:0];

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] cnt_inc;
  logic       heater_q, heater_d;
  logic       cooler_q, cooler_d;

  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (T < 8'd15) begin
          state_d = StHeat;
          cnt_d   = 8'd1;
        end else if (T > 8'd35) begin
          state_d = StCool;
          cnt_d   = 8'd1;
        end
      end
      StHeat: begin
        // Over-temperature exit ignores the minimum-on dwell.
        if ((T > 8'd45) || ((T >= 8'd30) && (cnt_q >= MinOn))) begin
          state_d = StGuard;
          cnt_d   = 8'd1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StCool: begin
        if ((T < 8'd25) && (cnt_q >= MinOn)) begin
          state_d = StGuard;
          cnt_d   = 8'd1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StGuard: begin
        if (cnt_q >= GuardCyc) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    heater_d = (state_d == StHeat);
    cooler_d = (state_d == StCool);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= 8'd0;
      heater_q <= 1'b0;
      cooler_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      heater_q <= heater_d;
      cooler_q <= cooler_d;
    end
  end

  assign Heater = heater_q;
  assign Cooler = cooler_q;
  assign STATE  = state_q;

`ifdef INCUBATOR_ALARM_EN
  logic [1:0] qual_q, qual_d;
  logic       alarm_q, alarm_d;

  always_comb begin
    qual_d  = qual_q;
    alarm_d = alarm_q;
    if (T >= 8'd50) begin
      if (qual_q != 2'd3) begin
        qual_d = qual_q + 2'd1;
      end
    end else begin
      qual_d = 2'd0;
    end
    // Set on the fourth consecutive hot sample; hold with hysteresis down to 40.
    if (alarm_q) begin
      alarm_d = (T >= 8'd40);
    end else if ((T >= 8'd50) && (qual_q == 2'd3)) begin
      alarm_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qual_q  <= 2'd0;
      alarm_q <= 1'b0;
    end else begin
      qual_q  <= qual_d;
      alarm_q <= alarm_d;
    end
  end

  assign ALARM = alarm_q;
`else
  assign ALARM = 1'b0;
`endif

endmodule

// File: tb/tb_incubator_sched.sv
// Directed-vector bench for incubator_sched; expected values are hand-derived constants.
module tb_incubator_sched;

`ifdef INCUBATOR_ALARM_EN
  localparam bit AlarmEn = 1'b1;
`else
  localparam bit AlarmEn = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] T;
  logic       Heater;
  logic       Cooler;
  logic [1:0] STATE;
  logic       ALARM;

  int vectors;
  int miscompares;

  incubator_sched #(
    .MIN_ON   (16),
    .GUARD_CYC(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .T     (T),
    .Heater(Heater),
    .Cooler(Cooler),
    .STATE (STATE),
    .ALARM (ALARM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    T     = 8'd25;
    #2;
    vectors++;
    if ({STATE, Heater, Cooler, ALARM} !== 5'b00000) begin
      miscompares++;
      $display("FAIL reset_state: got %b required %b", {STATE, Heater, Cooler, ALARM}, 5'b00000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    vectors++;
    if (STATE !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_idle_hold: STATE=%b required 00", STATE);
    end
  endtask

  task automatic test_heat_cycle();
    T = 8'd10;
    tick();
    vectors++;
    if (STATE !== 2'b01 || Heater !== 1'b1) begin
      miscompares++;
      $display("FAIL heat_entry: STATE=%b Heater=%b required 01/1", STATE, Heater);
    end
    // Entered with CNT=1; it takes 15 more edges to reach 16.
    for (int i = 1; i <= 15; i++) begin
      if (i == 3) T = 8'd32;
      tick();
      vectors++;
      if (Heater !== 1'b1 || Cooler !== 1'b0) begin
        miscompares++;
        $display("FAIL heat_min_on[%0d]: Heater=%b Cooler=%b required 1/0", i, Heater, Cooler);
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (STATE !== 2'b11 || Heater !== 1'b0) begin
        miscompares++;
        $display("FAIL heat_guard[%0d]: STATE=%b Heater=%b required 11/0", i, STATE, Heater);
      end
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (STATE !== 2'b00) begin
        miscompares++;
        $display("FAIL heat_to_idle[%0d]: STATE=%b required 00", i, STATE);
      end
    end
  endtask

  task automatic test_emergency();
    T = 8'd10;
    tick();
    tick();
    T = 8'd46;
    tick();
    vectors++;
    if (STATE !== 2'b11 || Heater !== 1'b0) begin
      miscompares++;
      $display("FAIL emerg_exit: STATE=%b Heater=%b required 11/0", STATE, Heater);
    end
    T = 8'd20;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (STATE !== 2'b11) begin
        miscompares++;
        $display("FAIL emerg_guard[%0d]: STATE=%b required 11", i, STATE);
      end
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (STATE !== 2'b00 || Heater !== 1'b0) begin
        miscompares++;
        $display("FAIL emerg_idle[%0d]: STATE=%b Heater=%b required 00/0", i, STATE, Heater);
      end
    end
  endtask

  task automatic test_changeover();
    int  zeros;
    bit  got_heat;
    T = 8'd40;
    tick();
    vectors++;
    if (STATE !== 2'b10 || Cooler !== 1'b1) begin
      miscompares++;
      $display("FAIL cool_entry: STATE=%b Cooler=%b required 10/1", STATE, Cooler);
    end
    T = 8'd30;
    for (int i = 0; i < 15; i++) tick();
    T        = 8'd10;
    zeros    = 0;
    got_heat = 1'b0;
    for (int i = 0; i < 12 && !got_heat; i++) begin
      tick();
      vectors++;
      if (Heater === 1'b1 && Cooler === 1'b1) begin
        miscompares++;
        $display("FAIL changeover_overlap[%0d]: Heater=1 Cooler=1 required not both", i);
      end
      if (Heater === 1'b1) got_heat = 1'b1;
      else if (Cooler === 1'b0) zeros++;
    end
    vectors++;
    if (!got_heat || zeros != 5) begin
      miscompares++;
      $display("FAIL changeover_gap: heat=%0d zero_cycles=%0d required 1/5", got_heat, zeros);
    end
  endtask

  task automatic test_boundaries();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    T = 8'd15;
    tick();
    vectors++;
    if (STATE !== 2'b00) begin
      miscompares++;
      $display("FAIL bound_t15: STATE=%b required 00", STATE);
    end
    T = 8'd35;
    tick();
    vectors++;
    if (STATE !== 2'b00) begin
      miscompares++;
      $display("FAIL bound_t35: STATE=%b required 00", STATE);
    end
    T = 8'd14;
    tick();
    vectors++;
    if (STATE !== 2'b01) begin
      miscompares++;
      $display("FAIL bound_t14: STATE=%b required 01", STATE);
    end
    T = 8'd46;
    tick();
    T = 8'd20;
    for (int i = 0; i < 4; i++) tick();
    T = 8'd36;
    tick();
    vectors++;
    if (STATE !== 2'b10) begin
      miscompares++;
      $display("FAIL bound_t36: STATE=%b required 10", STATE);
    end
    T = 8'd25;
    for (int i = 0; i < 20; i++) tick();
    vectors++;
    if (STATE !== 2'b10 || Cooler !== 1'b1) begin
      miscompares++;
      $display("FAIL bound_cool_t25: STATE=%b Cooler=%b required 10/1", STATE, Cooler);
    end
  endtask

  task automatic test_reset_mid_cool();
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (STATE !== 2'b00 || Cooler !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: STATE=%b Cooler=%b required 00/0", STATE, Cooler);
    end
    T     = 8'd40;
    rst_n = 1'b1;
    tick();
    vectors++;
    if (STATE !== 2'b10 || Cooler !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_recover: STATE=%b Cooler=%b required 10/1", STATE, Cooler);
    end
  endtask

  task automatic test_alarm();
    logic [7:0] t_seq [10] = '{8'd50, 8'd50, 8'd50, 8'd49, 8'd55, 8'd55, 8'd55, 8'd55,
                               8'd40, 8'd39};
    logic       a_seq [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic       exp_a;
    #2;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      T = t_seq[i];
      tick();
      exp_a = a_seq[i] & AlarmEn;
      vectors++;
      if (ALARM !== exp_a) begin
        miscompares++;
        $display("FAIL alarm[%0d] T=%0d: ALARM=%b required %b", i, t_seq[i], ALARM, exp_a);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    T           = 8'd25;
    test_reset();
    test_heat_cycle();
    test_emergency();
    test_changeover();
    test_boundaries();
    test_reset_mid_cool();
    test_alarm();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
